// File: rtl/datamover_pkg.sv
// Shared definitions for the datamover: register map, job FSM states and job descriptor.
package datamover_pkg;

    localparam int unsigned REG_AW = 9;

    localparam logic [REG_AW-1:0] REG_TRIGGER    = 9'h000;
    localparam logic [REG_AW-1:0] REG_STATUS     = 9'h004;
    localparam logic [REG_AW-1:0] REG_SOFT_CLEAR = 9'h008;
    localparam logic [REG_AW-1:0] REG_SRC        = 9'h040;
    localparam logic [REG_AW-1:0] REG_DST        = 9'h044;
    localparam logic [REG_AW-1:0] REG_LEN        = 9'h048;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RD,
        ST_RWAIT,
        ST_WR,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] len;
    } job_t;

    // Byte-enable merge of a 32-bit peripheral write into a config register.
    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/datamover_job_fifo.sv
// Pending-job queue: DEPTH-entry synchronous FIFO of job descriptors with occupancy count.
module datamover_job_fifo
    import datamover_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear,
    input  logic       push,
    input  logic       pop,
    input  job_t       din,
    output job_t       dout,
    output logic       full,
    output logic       empty,
    output logic [7:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    job_t             mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] cnt;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = 8'(cnt);
    assign dout    = mem[rptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_ok) wptr <= ptr_next(wptr);
            if (pop_ok)  rptr <= ptr_next(rptr);
            if (push_ok && !pop_ok)      cnt <= cnt + CNT_W'(1);
            else if (!push_ok && pop_ok) cnt <= cnt - CNT_W'(1);
        end
    end

    // Storage carries no reset; entries are only observed once written.
    always_ff @(posedge clk_i) begin
        if (push_ok && !clear) mem[wptr] <= din;
    end

endmodule

// File: rtl/datamover.sv
// Memory-to-memory copy engine: peripheral-programmed jobs, word-by-word TCDM read/write copy.
module datamover
    import datamover_pkg::*;
#(
    parameter int unsigned ID                  = 8,
    parameter int unsigned DW                  = 32,
    parameter int unsigned AW                  = 32,
    parameter int unsigned N_CORES             = 1,
    parameter int unsigned N_CONTEXT           = 2,
    parameter int unsigned MISALIGNED_ACCESSES = 0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               test_mode_i,
    output logic [N_CORES-1:0] evt_o,

    input  logic               periph_req_i,
    output logic               periph_gnt_o,
    input  logic [31:0]        periph_add_i,
    input  logic               periph_wen_i,
    input  logic [3:0]         periph_be_i,
    input  logic [31:0]        periph_data_i,
    input  logic [ID-1:0]      periph_id_i,
    output logic [31:0]        periph_r_data_o,
    output logic               periph_r_valid_o,
    output logic [ID-1:0]      periph_r_id_o,

    output logic               tcdm_req_o,
    input  logic               tcdm_gnt_i,
    output logic [AW-1:0]      tcdm_add_o,
    output logic               tcdm_wen_o,
    output logic [DW/8-1:0]    tcdm_be_o,
    output logic [DW-1:0]      tcdm_data_o,
    input  logic [DW-1:0]      tcdm_r_data_i,
    input  logic               tcdm_r_valid_i,
    output logic               tcdm_r_ready_o,
    output logic               tcdm_user_o,
    output logic [ID-1:0]      tcdm_id_o,
    output logic [6:0]         tcdm_ecc_o,
    output logic               tcdm_ereq_o,
    output logic               tcdm_r_eready_o
);

    localparam int unsigned   BW        = DW / 8;
    localparam logic [AW-1:0] STRIDE    = AW'(BW);
    localparam logic [AW-1:0] ADDR_MASK = (MISALIGNED_ACCESSES != 0) ? '1 : ~AW'(BW - 1);

    state_e       state;
    logic [31:0]  src_q, dst_q, len_q;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [31:0]  remain;

    logic [REG_AW-1:0] reg_addr;
    logic        acc, wr_acc, push, soft_clear, pop, busy;
    logic        fifo_full, fifo_empty;
    logic [7:0]  fifo_count;
    job_t        head;
    logic [31:0] rdata_c;
    logic        unused_inputs;

    assign tcdm_r_ready_o  = 1'b1;
    assign tcdm_user_o     = 1'b0;
    assign tcdm_id_o       = '0;
    assign tcdm_ecc_o      = '0;
    assign tcdm_ereq_o     = 1'b0;
    assign tcdm_r_eready_o = 1'b0;
    assign unused_inputs   = ^{test_mode_i, periph_add_i[31:REG_AW]};

    // A TRIGGER against a full queue is stalled until a job is popped.
    assign reg_addr     = periph_add_i[REG_AW-1:0];
    assign periph_gnt_o = periph_req_i &&
                          !(!periph_wen_i && (reg_addr == REG_TRIGGER) && fifo_full);
    assign acc          = periph_req_i && periph_gnt_o;
    assign wr_acc       = acc && !periph_wen_i;
    assign push         = wr_acc && (reg_addr == REG_TRIGGER);
    assign soft_clear   = wr_acc && (reg_addr == REG_SOFT_CLEAR);
    assign pop          = (state == ST_LOAD) && !soft_clear;
    assign busy         = (state != ST_IDLE) || !fifo_empty;

    always_comb begin
        rdata_c = '0;
        case (reg_addr)
            REG_STATUS: rdata_c = {16'h0, fifo_count, 7'h0, busy};
            REG_SRC:    rdata_c = src_q;
            REG_DST:    rdata_c = dst_q;
            REG_LEN:    rdata_c = len_q;
            default:    rdata_c = '0;
        endcase
    end

    datamover_job_fifo #(
        .DEPTH (N_CONTEXT)
    ) u_job_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear  (soft_clear),
        .push   (push),
        .pop    (pop),
        .din    ('{src: src_q, dst: dst_q, len: len_q}),
        .dout   (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // Peripheral response and config registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            periph_r_valid_o <= 1'b0;
            periph_r_id_o    <= '0;
            periph_r_data_o  <= '0;
            src_q            <= '0;
            dst_q            <= '0;
            len_q            <= '0;
        end else begin
            periph_r_valid_o <= acc;
            if (acc) begin
                periph_r_id_o   <= periph_id_i;
                periph_r_data_o <= periph_wen_i ? rdata_c : 32'h0;
            end
            if (wr_acc) begin
                case (reg_addr)
                    REG_SRC: src_q <= be_merge(src_q, periph_data_i, periph_be_i);
                    REG_DST: dst_q <= be_merge(dst_q, periph_data_i, periph_be_i);
                    REG_LEN: len_q <= be_merge(len_q, periph_data_i, periph_be_i);
                    default: ;
                endcase
            end
        end
    end

    // Job FSM; TCDM request fields only change on grant, so they hold during stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            tcdm_req_o  <= 1'b0;
            tcdm_add_o  <= '0;
            tcdm_wen_o  <= 1'b0;
            tcdm_be_o   <= '0;
            tcdm_data_o <= '0;
            evt_o       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            remain      <= '0;
        end else if (soft_clear) begin
            state      <= ST_IDLE;
            tcdm_req_o <= 1'b0;
            tcdm_wen_o <= 1'b0;
            tcdm_be_o  <= '0;
            evt_o      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    rd_ptr <= AW'(head.src) + STRIDE;
                    wr_ptr <= AW'(head.dst);
                    remain <= head.len;
                    if (head.len == 32'd0) begin
                        state <= ST_DONE;
                        evt_o <= '1;
                    end else begin
                        state      <= ST_RD;
                        tcdm_req_o <= 1'b1;
                        tcdm_wen_o <= 1'b1;
                        tcdm_be_o  <= '1;
                        tcdm_add_o <= AW'(head.src) & ADDR_MASK;
                    end
                end
                ST_RD: begin
                    if (tcdm_gnt_i) begin
                        state      <= ST_RWAIT;
                        tcdm_req_o <= 1'b0;
                        tcdm_be_o  <= '0;
                    end
                end
                ST_RWAIT: begin
                    if (tcdm_r_valid_i) begin
                        state       <= ST_WR;
                        tcdm_data_o <= tcdm_r_data_i;
                        tcdm_req_o  <= 1'b1;
                        tcdm_wen_o  <= 1'b0;
                        tcdm_be_o   <= '1;
                        tcdm_add_o  <= wr_ptr & ADDR_MASK;
                        wr_ptr      <= wr_ptr + STRIDE;
                    end
                end
                ST_WR: begin
                    if (tcdm_gnt_i) begin
                        if (remain == 32'd1) begin
                            state      <= ST_DONE;
                            tcdm_req_o <= 1'b0;
                            tcdm_be_o  <= '0;
                            evt_o      <= '1;
                        end else begin
                            state      <= ST_RD;
                            remain     <= remain - 32'd1;
                            tcdm_wen_o <= 1'b1;
                            tcdm_add_o <= rd_ptr & ADDR_MASK;
                            rd_ptr     <= rd_ptr + STRIDE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    evt_o <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_datamover.sv
// Directed bench: DW=32 instance for copy/queue tests, DW=128 instance for alignment and soft clear.
module tb_datamover;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Shared peripheral stimulus, routed to one instance by sel.
    logic        sel = 1'b0;
    logic        p_req = 1'b0, p_wen = 1'b0;
    logic [31:0] p_add = '0, p_data = '0;
    logic [3:0]  p_be = '0;
    logic [7:0]  p_id = '0;

    logic        pgnt0, prv0, pgnt1, prv1;
    logic [31:0] prd0, prd1;
    logic [7:0]  prid0, prid1;
    logic [0:0]  evt0, evt1;

    logic        req0, wen0, rready0, user0, ereq0, reready0;
    logic [31:0] add0, data0;
    logic [3:0]  be0;
    logic [7:0]  tid0;
    logic [6:0]  ecc0;
    logic        gnt_t0 = 1'b1, rvalid_t0 = 1'b0;
    logic [31:0] rdata_t0 = '0;

    logic        req1, wen1, rready1, user1, ereq1, reready1;
    logic [31:0] add1;
    logic [127:0] data1;
    logic [15:0] be1;
    logic [7:0]  tid1;
    logic [6:0]  ecc1;
    logic        gnt_t1 = 1'b1, rvalid_t1 = 1'b0;
    logic [127:0] rdata_t1 = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978;

    wire         cur_gnt   = sel ? pgnt1 : pgnt0;
    wire         cur_rv    = sel ? prv1  : prv0;
    wire [31:0]  cur_rdata = sel ? prd1  : prd0;
    wire [7:0]   cur_rid   = sel ? prid1 : prid0;

    datamover #(.DW(32), .N_CONTEXT(2)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .test_mode_i(1'b0), .evt_o(evt0),
        .periph_req_i(p_req && !sel), .periph_gnt_o(pgnt0), .periph_add_i(p_add),
        .periph_wen_i(p_wen), .periph_be_i(p_be), .periph_data_i(p_data), .periph_id_i(p_id),
        .periph_r_data_o(prd0), .periph_r_valid_o(prv0), .periph_r_id_o(prid0),
        .tcdm_req_o(req0), .tcdm_gnt_i(gnt_t0), .tcdm_add_o(add0), .tcdm_wen_o(wen0),
        .tcdm_be_o(be0), .tcdm_data_o(data0), .tcdm_r_data_i(rdata_t0),
        .tcdm_r_valid_i(rvalid_t0), .tcdm_r_ready_o(rready0), .tcdm_user_o(user0),
        .tcdm_id_o(tid0), .tcdm_ecc_o(ecc0), .tcdm_ereq_o(ereq0), .tcdm_r_eready_o(reready0)
    );

    datamover #(.DW(128), .N_CONTEXT(2), .MISALIGNED_ACCESSES(0)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .test_mode_i(1'b0), .evt_o(evt1),
        .periph_req_i(p_req && sel), .periph_gnt_o(pgnt1), .periph_add_i(p_add),
        .periph_wen_i(p_wen), .periph_be_i(p_be), .periph_data_i(p_data), .periph_id_i(p_id),
        .periph_r_data_o(prd1), .periph_r_valid_o(prv1), .periph_r_id_o(prid1),
        .tcdm_req_o(req1), .tcdm_gnt_i(gnt_t1), .tcdm_add_o(add1), .tcdm_wen_o(wen1),
        .tcdm_be_o(be1), .tcdm_data_o(data1), .tcdm_r_data_i(rdata_t1),
        .tcdm_r_valid_i(rvalid_t1), .tcdm_r_ready_o(rready1), .tcdm_user_o(user1),
        .tcdm_id_o(tid1), .tcdm_ecc_o(ecc1), .tcdm_ereq_o(ereq1), .tcdm_r_eready_o(reready1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // TCDM memory model and monitors, all evaluated on the falling edge.
    logic [31:0] mem [0:1023];
    logic [31:0] src_data [8] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004,
                                  32'h5555_0005, 32'h6666_0006, 32'h7777_0007, 32'h8888_0008};
    logic [31:0] log_add [$];
    logic        log_wen [$];
    logic [31:0] rd1_log [$];
    logic [31:0] evt_last [16];
    logic [31:0] last_wr0 = '0;
    logic [31:0] rd_word0 = '0;
    logic [68:0] hold_val = '0;
    logic        hold_chk = 1'b0, stall_en = 1'b0, rv_pend0 = 1'b0, rv_pend1 = 1'b0;
    int          rv_wait0 = 0;
    int          evt0_cnt = 0, evt1_cnt = 0;

    always @(negedge clk) begin
        rvalid_t0 = 1'b0;
        if (rv_pend0) begin
            if (rv_wait0 == 0) begin
                rvalid_t0 = 1'b1;
                rdata_t0  = rd_word0;
                rv_pend0  = 1'b0;
            end else begin
                rv_wait0--;
            end
        end
        if (evt0[0]) begin
            if (evt0_cnt < 16) evt_last[evt0_cnt] = last_wr0;
            evt0_cnt++;
        end
        if (hold_chk && req0) chk("stall_stable", {wen0, add0, data0, be0}, hold_val);
        gnt_t0   = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        hold_chk = req0 && !gnt_t0;
        hold_val = {wen0, add0, data0, be0};
        if (req0 && gnt_t0) begin
            log_add.push_back(add0);
            log_wen.push_back(wen0);
            if (wen0) begin
                rd_word0 = mem[add0[11:2]];
                rv_pend0 = 1'b1;
                rv_wait0 = stall_en ? int'($urandom_range(0, 5)) : 0;
            end else begin
                mem[add0[11:2]] = data0;
                last_wr0 = add0;
            end
        end

        rvalid_t1 = rv_pend1;
        rv_pend1  = 1'b0;
        if (evt1[0]) evt1_cnt++;
        if (req1 && gnt_t1 && wen1) begin
            rd1_log.push_back(add1);
            rv_pend1 = 1'b1;
        end
    end

    int          last_wait = 0;
    logic [7:0]  id_seq = 8'h5A;
    logic [31:0] rv;

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, output logic [31:0] rd);
        int wt;
        logic [7:0] id;
        wt = 0;
        id = id_seq;
        id_seq = id_seq + 8'd1;
        @(negedge clk);
        p_req = 1'b1; p_wen = w; p_add = a; p_data = d; p_be = be; p_id = id;
        #1;
        while (!cur_gnt && wt < 100) begin
            @(negedge clk);
            #1;
            wt++;
        end
        last_wait = wt;
        if (wt >= 100) begin
            chk("periph_gnt_timeout", 0, 1);
            p_req = 1'b0;
            rd = '0;
            return;
        end
        @(negedge clk);
        p_req = 1'b0;
        chk("r_valid", cur_rv, 1);
        chk("r_id", cur_rid, id);
        rd = cur_rdata;
        if (!w) chk("wr_rdata_zero", rd, 0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus(1'b0, a, d, 4'hF, rv);
    endtask

    task automatic wait_evt0(input int target);
        int n;
        n = 0;
        while (evt0_cnt < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("evt_wait", evt0_cnt >= target, 1);
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int k = 0; k < 8; k++) mem[64 + k] = src_data[k];

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_evt", evt0, 0);
        chk("rst_tcdm_req", req0, 0);
        chk("rst_r_valid", prv0, 0);
        chk("rst_r_ready", rready0, 1);
        chk("rst_tcdm_req1", req1, 0);
        bus(1'b1, 32'h04, 32'h0, 4'hF, rv);
        chk("status_after_rst", rv, 0);

        // Basic copy of four words; LEN written through a byte-enable merge.
        wr(32'h0000_1040, 32'h100);
        wr(32'h44, 32'h200);
        wr(32'h48, 32'h0);
        bus(1'b0, 32'h48, 32'hAAAA_AA04, 4'b0001, rv);
        bus(1'b1, 32'h40, 32'h0, 4'hF, rv);
        chk("src_readback", rv, 32'h100);
        bus(1'b1, 32'h48, 32'h0, 4'hF, rv);
        chk("len_be_merge", rv, 32'h4);
        wr(32'h10, 32'hDEAD_BEEF);
        bus(1'b1, 32'h10, 32'h0, 4'hF, rv);
        chk("unmapped_read", rv, 0);
        log_add.delete(); log_wen.delete();
        wr(32'h00, 32'h0);
        bus(1'b1, 32'h04, 32'h0, 4'hF, rv);
        chk("status_busy", rv[0], 1);
        wait_evt0(1);
        chk("basic_txn_count", log_add.size(), 8);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("basic_rd_add%0d", k), log_add[2*k], 32'h100 + 32'(4*k));
            chk($sformatf("basic_rd_wen%0d", k), log_wen[2*k], 1);
            chk($sformatf("basic_wr_add%0d", k), log_add[2*k+1], 32'h200 + 32'(4*k));
            chk($sformatf("basic_wr_wen%0d", k), log_wen[2*k+1], 0);
            chk($sformatf("basic_dst%0d", k), mem[128 + k], src_data[k]);
        end
        repeat (3) @(negedge clk);
        chk("basic_evt_once", evt0_cnt, 1);
        bus(1'b1, 32'h04, 32'h0, 4'hF, rv);
        chk("status_idle", rv, 0);

        // Same job with random grant stalls and read latency.
        stall_en = 1'b1;
        log_add.delete(); log_wen.delete();
        wr(32'h44, 32'h280);
        wr(32'h00, 32'h0);
        wait_evt0(2);
        stall_en = 1'b0;
        chk("stall_txn_count", log_add.size(), 8);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("stall_wr_add%0d", k), log_add[2*k+1], 32'h280 + 32'(4*k));
            chk($sformatf("stall_dst%0d", k), mem[160 + k], src_data[k]);
        end

        // Long job running, then three queued jobs; the third waits for a free slot.
        wr(32'h44, 32'h300);
        wr(32'h48, 32'h8);
        wr(32'h00, 32'h0);
        wr(32'h44, 32'h400);
        wr(32'h48, 32'h2);
        wr(32'h00, 32'h0);
        chk("trig_b_nowait", last_wait, 0);
        wr(32'h44, 32'h500);
        wr(32'h00, 32'h0);
        chk("trig_c_nowait", last_wait, 0);
        wr(32'h44, 32'h600);
        wr(32'h00, 32'h0);
        chk("trig_d_held", last_wait > 0, 1);
        wait_evt0(6);
        chk("queue_evt_a", evt_last[2], 32'h31C);
        chk("queue_evt_b", evt_last[3], 32'h404);
        chk("queue_evt_c", evt_last[4], 32'h504);
        chk("queue_evt_d", evt_last[5], 32'h604);
        chk("queue_a_last_word", mem[199], src_data[7]);
        chk("queue_d_word1", mem[385], src_data[1]);

        // Zero-length job completes with no TCDM traffic.
        wr(32'h48, 32'h0);
        log_add.delete(); log_wen.delete();
        wr(32'h00, 32'h0);
        cnt = 0;
        while (!evt0[0] && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("len0_evt_latency", evt0[0] && cnt <= 3, 1);
        repeat (3) @(negedge clk);
        chk("len0_no_tcdm", log_add.size(), 0);

        // Wide instance: aligned addressing and soft clear mid-job.
        sel = 1'b1;
        wr(32'h40, 32'h104);
        wr(32'h44, 32'h800);
        wr(32'h48, 32'd10);
        wr(32'h00, 32'h0);
        cnt = 0;
        while (rd1_log.size() < 2 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("wide_reads_seen", rd1_log.size() >= 2, 1);
        if (rd1_log.size() >= 2) begin
            chk("wide_rd_add0", rd1_log[0], 32'h100);
            chk("wide_rd_add1", rd1_log[1], 32'h110);
        end
        wr(32'h08, 32'h0);
        chk("clear_req_low", req1, 0);
        bus(1'b1, 32'h04, 32'h0, 4'hF, rv);
        chk("clear_status", rv, 0);
        repeat (10) @(negedge clk);
        chk("clear_no_evt", evt1_cnt, 0);
        chk("clear_req_still_low", req1, 0);
        bus(1'b1, 32'h40, 32'h0, 4'hF, rv);
        chk("clear_keeps_src", rv, 32'h104);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/datamover.md
Name: datamover

Overview:
- Programmable memory-to-memory copy engine ("datamover") for the HCI shared-memory cluster.
- Software programs source, destination and length over a 32-bit peripheral target port and queues the job.
- The engine then copies the data word by word through one HCI core initiator port of width DW. This is a narrow port when DW=32, a wide HWPE port when DW=N*32.
- It raises an event on job completion. Several instances sit behind a peripheral demux and in front of the HCI interconnect.

Parameters:
- ID, 8: peripheral transaction ID width.
- DW, 32: TCDM data width; a multiple of 32.
- AW, 32: TCDM address width.
- N_CORES, 1: width of evt_o.
- N_CONTEXT, 2: depth of the pending-job queue; must be at least 1.
- MISALIGNED_ACCESSES, 0: 0 forces the low log2(DW/8) bits of TCDM addresses to zero. 1 uses addresses as given.

Ports:
- clk_i in 1: clock.
- rst_ni in 1: asynchronous active-low reset.
- test_mode_i in 1: unused; no functional effect.
- evt_o out N_CORES: job-done pulse, replicated on all bits.
- periph_req_i in 1; periph_gnt_o out 1.
- periph_add_i in 32; periph_wen_i in 1 (1 = read); periph_be_i in 4.
- periph_data_i in 32; periph_id_i in ID.
- periph_r_data_o out 32; periph_r_valid_o out 1; periph_r_id_o out ID.
- tcdm_req_o out 1; tcdm_gnt_i in 1.
- tcdm_add_o out AW; tcdm_wen_o out 1 (1 = read); tcdm_be_o out DW/8.
- tcdm_data_o out DW; tcdm_r_data_i in DW; tcdm_r_valid_i in 1; tcdm_r_ready_o out 1.
- tcdm_user_o, tcdm_id_o, tcdm_ecc_o, tcdm_ereq_o, tcdm_r_eready_o out: driven to all-zero.

Behaviour:
- Reset values: all outputs 0, except tcdm_r_ready_o, which is constantly 1. FSM resets to IDLE; queue empty; registers 0.
- Register map, decoded on periph_add_i[8:0] (upper bits ignored):
  - 0x00 TRIGGER (W): a write pushes {SRC, DST, LEN} into the queue.
  - 0x04 STATUS (R): bit0 = busy (FSM not IDLE or queue non-empty); bits[15:8] = queued job count.
  - 0x08 SOFT_CLEAR (W): a write returns the FSM to IDLE and empties the queue. Config registers are kept. An in-flight TCDM request is dropped without handshake completion.
  - 0x40 SRC (RW), 0x44 DST (RW): byte addresses.
  - 0x48 LEN (RW): number of DW-bit words to copy.
  - Unmapped reads return 0; unmapped writes are ignored.
- Config register writes honour periph_be_i per byte.
- Peripheral handshake:
  - periph_gnt_o = periph_req_i, except that a TRIGGER write while the queue is full is not granted (gnt=0) until space frees.
  - periph_r_valid_o pulses exactly one cycle after every granted request, reads and writes alike.
  - periph_r_id_o and periph_r_data_o are registered with that pulse. r_data is 0 for writes.
- Job FSM states and transitions:
  - IDLE → LOAD when the queue is non-empty. LOAD pops the head job and sets i=0.
  - LOAD → DONE if LEN=0; otherwise → RD.
  - RD: req=1, wen=1, add=SRC+i*(DW/8), be all ones. On gnt → RWAIT.
  - RWAIT: on tcdm_r_valid_i, latch r_data → WR.
  - WR: req=1, wen=0, add=DST+i*(DW/8), data=latched word, be all ones. On gnt: i++; → DONE if i==LEN, else → RD.
  - DONE: evt_o = all ones for exactly one cycle → IDLE.
- Address arithmetic is modulo 2^AW (wrap-around). Addresses are masked per MISALIGNED_ACCESSES.
- tcdm_r_valid_i outside RWAIT is ignored; this covers write responses. Writes complete on gnt.
- req, add, wen, data and be stay stable while req=1 and gnt=0.
- Simultaneous events:
  - A TRIGGER push and a LOAD pop in the same cycle are both performed.
  - SOFT_CLEAR has priority over a TRIGGER in the same cycle.
  - Register writes during a job do not affect the running job, which uses its queued copy.

Decomposition:
- Package datamover_pkg: register offsets, FSM state enum, job struct {src, dst, len}.
- One sub-module, datamover_job_fifo: N_CONTEXT-deep synchronous FIFO with push, pop, full, empty and count.

Test Plan:
- Reset, then STATUS read → r_valid one cycle after gnt; r_data=0; r_id echoes the request ID; evt_o=0; tcdm_req_o=0.
- SRC=0x100, DST=0x200, LEN=4, TRIGGER (DW=32) → reads 0x100, 0x104, 0x108, 0x10C alternate with writes 0x200, 0x204, 0x208, 0x20C. Destination equals source data; one evt_o pulse; STATUS.busy returns to 0.
- The same job with random gnt stalls and r_valid delays of 0–5 cycles → request fields stay stable during stalls; data is correct; exactly 8 granted transactions.
- Three back-to-back TRIGGERs with N_CONTEXT=2 while the first job is running → third TRIGGER gnt held low until LOAD; three evt pulses in order.
- LEN=0 TRIGGER → no TCDM request; evt pulse within 3 cycles.
- DW=128, SRC=0x104, MISALIGNED_ACCESSES=0 → first read address 0x100, stride 16; SOFT_CLEAR mid-job → IDLE, STATUS=0, no evt.
